// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: loads a parallel word over valid/ready and shifts it
// out LSB first, one bit per enabled clock, repeating it a programmed number of times.
//
// state | meaning
// IDLE  | waiting for a load; load_ready high
// SHIFT | shifting the held word out, one bit per enabled edge
module serial_pattern_tx #(
    parameter int WIDTH = 10,
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             load_valid_i,
    output logic             load_ready_o,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic [REP_W-1:0] load_reps_i,
    output logic             out_o,
    output logic             out_valid_o,
    output logic             frame_start_o,
    output logic             done_o,
    output logic             busy_o
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d, sr_q, sr_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             out_q, out_d, out_valid_q, out_valid_d;
    logic             frame_start_q, frame_start_d, done_q, done_d;

    logic             do_shift;
    logic [WIDTH-1:0] sr_v, hold_v;
    logic [CW-1:0]    cnt_v;
    logic [REP_W-1:0] rep_v;

    always_comb begin
        state_d       = state_q;
        hold_d        = hold_q;
        sr_d          = sr_q;
        bit_cnt_d     = bit_cnt_q;
        rep_cnt_d     = rep_cnt_q;
        out_d         = out_q;
        out_valid_d   = 1'b0;
        frame_start_d = 1'b0;
        done_d        = 1'b0;
        do_shift      = 1'b0;
        sr_v          = sr_q;
        hold_v        = hold_q;
        cnt_v         = bit_cnt_q;
        rep_v         = rep_cnt_q;

        if (clr_i) begin
            state_d = IDLE;
            out_d   = 1'b0;
        end else if (state_q == IDLE) begin
            if (load_valid_i) begin
                hold_v    = load_data_i;
                sr_v      = load_data_i;
                cnt_v     = '0;
                rep_v     = (load_reps_i == '0) ? REP_W'(1) : load_reps_i;
                hold_d    = hold_v;
                sr_d      = sr_v;
                bit_cnt_d = cnt_v;
                rep_cnt_d = rep_v;
                state_d   = SHIFT;
                // A load taken in the done cycle emits bit 0 on the same edge so
                // back-to-back words stream without a bubble.
                do_shift  = done_q && en_i;
            end
        end else begin
            do_shift = en_i;
        end

        if (do_shift) begin
            out_d         = sr_v[0];
            out_valid_d   = 1'b1;
            frame_start_d = (cnt_v == '0);
            sr_d          = {1'b0, sr_v[WIDTH-1:1]};
            bit_cnt_d     = cnt_v + CW'(1);
            if (cnt_v == CW'(WIDTH - 1)) begin
                if (rep_v > REP_W'(1)) begin
                    rep_cnt_d = rep_v - REP_W'(1);
                    sr_d      = hold_v;
                    bit_cnt_d = '0;
                end else begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            hold_q        <= '0;
            sr_q          <= '0;
            bit_cnt_q     <= '0;
            rep_cnt_q     <= '0;
            out_q         <= 1'b0;
            out_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            sr_q          <= sr_d;
            bit_cnt_q     <= bit_cnt_d;
            rep_cnt_q     <= rep_cnt_d;
            out_q         <= out_d;
            out_valid_q   <= out_valid_d;
            frame_start_q <= frame_start_d;
            done_q        <= done_d;
        end
    end

    assign load_ready_o  = (state_q == IDLE);
    assign busy_o        = (state_q == SHIFT);
    assign out_o         = out_q;
    assign out_valid_o   = out_valid_q;
    assign frame_start_o = frame_start_q;
    assign done_o        = done_q;
endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx; each task checks one scenario against
// hand-computed bit sequences. Observed vector: {out,out_valid,frame_start,done,load_ready,busy}.
module tb_serial_pattern_tx;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0, clr = 1'b0, load_valid = 1'b0;
    logic [9:0] load_data = '0;
    logic [3:0] load_reps = '0;
    logic       out, out_valid, frame_start, done, load_ready, busy;
    int         checks = 0, failures = 0;

    serial_pattern_tx #(.WIDTH(10), .REP_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .en_i(en), .clr_i(clr),
        .load_valid_i(load_valid), .load_ready_o(load_ready),
        .load_data_i(load_data), .load_reps_i(load_reps),
        .out_o(out), .out_valid_o(out_valid), .frame_start_o(frame_start),
        .done_o(done), .busy_o(busy)
    );

    always #5 clk = ~clk;

    wire [5:0] obs = {out, out_valid, frame_start, done, load_ready, busy};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 6'b000010) begin
            failures++;
            $display("FAIL reset got=%b exp=%b", obs, 6'b000010);
        end
        step(); step();
        rst_n = 1'b1;
        step();
        checks++;
        if (obs !== 6'b000010) begin
            failures++;
            $display("FAIL reset_release got=%b exp=%b", obs, 6'b000010);
        end
    endtask

    task automatic test_single();
        logic [9:0] exp_bits;
        logic [5:0] e;
        exp_bits   = 10'b0010101010;
        load_data  = exp_bits;
        load_reps  = 4'd1;
        load_valid = 1'b1;
        en         = 1'b1;
        step();
        load_valid = 1'b0;
        load_data  = 10'b1111111111;
        checks++;
        if (obs !== 6'b000001) begin
            failures++;
            $display("FAIL single_accept got=%b exp=%b", obs, 6'b000001);
        end
        for (int k = 0; k < 10; k++) begin
            step();
            e = {exp_bits[k], 1'b1, k == 0, k == 9, k == 9, k != 9};
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL single_bit%0d got=%b exp=%b", k, obs, e);
            end
        end
        step();
        checks++;
        if (obs[4:0] !== 5'b00010) begin
            failures++;
            $display("FAIL single_after got=%b exp=%b", obs[4:0], 5'b00010);
        end
    endtask

    task automatic test_repeat();
        logic [9:0] w;
        logic [5:0] e;
        w          = 10'b1100000001;
        load_data  = w;
        load_reps  = 4'd3;
        load_valid = 1'b1;
        en         = 1'b1;
        step();
        load_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            e = {w[i % 10], 1'b1, (i % 10) == 0, i == 29, i == 29, i != 29};
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL repeat_bit%0d got=%b exp=%b", i, obs, e);
            end
        end
        step();
        w          = 10'b0000111101;
        load_data  = w;
        load_reps  = 4'd0;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            e = {w[i], 1'b1, i == 0, i == 9, i == 9, i != 9};
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL reps0_bit%0d got=%b exp=%b", i, obs, e);
            end
        end
        step();
        checks++;
        if (obs[4:0] !== 5'b00010) begin
            failures++;
            $display("FAIL reps0_after got=%b exp=%b", obs[4:0], 5'b00010);
        end
    endtask

    task automatic test_stall();
        logic [9:0] w;
        logic [5:0] e;
        logic       last;
        int         k, c;
        w          = 10'b0110011010;
        load_data  = w;
        load_reps  = 4'd1;
        load_valid = 1'b1;
        en         = 1'b1;
        step();
        load_valid = 1'b0;
        k = 0;
        c = 0;
        last = 1'b0;
        while (k < 10 && c < 40) begin
            en = (c % 4 == 0) || (c % 4 == 3);
            step();
            if (en) begin
                e = {w[k], 1'b1, k == 0, k == 9, k == 9, k != 9};
                last = w[k];
                k++;
            end else begin
                e = {last, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
            end
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL stall_cyc%0d got=%b exp=%b", c, obs, e);
            end
            c++;
        end
        checks++;
        if (k != 10) begin
            failures++;
            $display("FAIL stall_timeout got=%0d exp=%0d", k, 10);
        end
        en = 1'b1;
        step();
    endtask

    task automatic test_abort();
        logic [9:0] a, b;
        logic [5:0] e;
        a          = 10'b1011001110;
        b          = 10'b0100110101;
        load_data  = a;
        load_reps  = 4'd2;
        load_valid = 1'b1;
        en         = 1'b1;
        step();
        load_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            e = {a[k], 1'b1, k == 0, 1'b0, 1'b0, 1'b1};
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL abort_pre%0d got=%b exp=%b", k, obs, e);
            end
        end
        clr = 1'b1;
        step();
        clr = 1'b0;
        checks++;
        if (obs !== 6'b000010) begin
            failures++;
            $display("FAIL abort_clr got=%b exp=%b", obs, 6'b000010);
        end
        load_data  = b;
        load_reps  = 4'd1;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        checks++;
        if (obs !== 6'b000001) begin
            failures++;
            $display("FAIL abort_reload got=%b exp=%b", obs, 6'b000001);
        end
        for (int k = 0; k < 10; k++) begin
            step();
            e = {b[k], 1'b1, k == 0, k == 9, k == 9, k != 9};
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL abort_new%0d got=%b exp=%b", k, obs, e);
            end
        end
        step();
        clr        = 1'b1;
        load_valid = 1'b1;
        step();
        clr        = 1'b0;
        load_valid = 1'b0;
        checks++;
        if (obs[2:0] !== 3'b010) begin
            failures++;
            $display("FAIL clr_idle_load got=%b exp=%b", obs[2:0], 3'b010);
        end
        step();
        checks++;
        if (obs[4:0] !== 5'b00010) begin
            failures++;
            $display("FAIL clr_idle_after got=%b exp=%b", obs[4:0], 5'b00010);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] a, b;
        logic [5:0] e;
        a          = 10'b1110001011;
        b          = 10'b0101100110;
        load_data  = a;
        load_reps  = 4'd1;
        load_valid = 1'b1;
        en         = 1'b1;
        step();
        load_data  = b;
        for (int i = 0; i < 20; i++) begin
            step();
            if (i == 10) load_valid = 1'b0;
            if (i < 10) e = {a[i], 1'b1, i == 0, i == 9, i == 9, i != 9};
            else        e = {b[i-10], 1'b1, i == 10, i == 19, i == 19, i != 19};
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL b2b_bit%0d got=%b exp=%b", i, obs, e);
            end
        end
        step();
        checks++;
        if (obs[4:0] !== 5'b00010) begin
            failures++;
            $display("FAIL b2b_after got=%b exp=%b", obs[4:0], 5'b00010);
        end
    endtask

    task automatic test_reset_midframe();
        logic [9:0] w;
        logic [5:0] e;
        w          = 10'b1001011011;
        load_data  = w;
        load_reps  = 4'd2;
        load_valid = 1'b1;
        en         = 1'b1;
        step();
        load_valid = 1'b0;
        for (int k = 0; k < 7; k++) step();
        e = {w[6], 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL rstmid_bit6 got=%b exp=%b", obs, e);
        end
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 6'b000010) begin
            failures++;
            $display("FAIL rstmid_async got=%b exp=%b", obs, 6'b000010);
        end
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (obs !== 6'b000010) begin
                failures++;
                $display("FAIL rstmid_idle%0d got=%b exp=%b", k, obs, 6'b000010);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_repeat();
        test_stall();
        test_abort();
        test_back_to_back();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
